button_event_scheduler: RTL

Arbitration and queueing stage between the per-button one-shot pulse generators and the game/VGA control logic. The block latches single-cycle button pulses from N sources and grants them round-robin into a small event FIFO. It presents the events to one consumer over a valid/ready handshake, so no press is lost while the consumer is busy. Sticky overrun reporting covers presses that arrive faster than they can be serviced.

---
 rtl/button_event_scheduler_if.sv | 27 ++
 rtl/button_event_scheduler.sv | 103 ++++++++++
 2 files changed

// File: rtl/button_event_scheduler_if.sv
// Event handshake bundle between the button scheduler (master) and its single consumer (slave).
interface button_event_scheduler_if #(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned ID_W  = $clog2(N_BTN);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             ev_valid;
  logic             ev_ready;
  logic [ID_W-1:0]  ev_id;
  logic [CNT_W-1:0] ev_count;

  modport master (
    output ev_valid,
    output ev_id,
    output ev_count,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_id,
    input  ev_count,
    output ev_ready
  );
endinterface

// File: rtl/button_event_scheduler.sv
// Latches one-shot button pulses, grants them round-robin into a small event FIFO and presents
// the head event over valid/ready, with sticky per-button overrun flags for merged presses.
module button_event_scheduler #(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_a_n,
  input  logic [N_BTN-1:0]       pulse_in,
  input  logic                   clear_ovr,
  output logic [N_BTN-1:0]       overrun,
  button_event_scheduler_if.master ev_bus
);
  localparam int unsigned ID_W  = $clog2(N_BTN);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] overrun_q, overrun_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             pop;
  logic             push_ok;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic [N_BTN-1:0] grant_oh;
  int unsigned      scan_idx;

  // A pop frees the slot the grant pushes into, so a full FIFO can still accept.
  assign pop     = (count_q != '0) && ev_bus.ev_ready;
  assign push_ok = (count_q < CNT_W'(FIFO_DEPTH)) || pop;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % N_BTN;
      if (!grant_valid && push_ok && pending_q[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(scan_idx);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_valid) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // A pulse coinciding with its own grant re-arms pending; otherwise it merges into the
  // already-pending press and is reported as lost.
  always_comb begin
    pending_d = (pending_q & ~grant_oh) | pulse_in;
    overrun_d = (clear_ovr ? '0 : overrun_q) | (pulse_in & pending_q & ~grant_oh);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (grant_idx == ID_W'(N_BTN - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  assign count_d = count_q + CNT_W'(grant_valid) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      pending_q <= '0;
      overrun_q <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rr_ptr_q  <= rr_ptr_d;
      count_q   <= count_d;
      if (grant_valid) begin
        mem_q[wr_ptr_q] <= grant_idx;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign ev_bus.ev_valid = (count_q != '0);
  assign ev_bus.ev_id    = mem_q[rd_ptr_q];
  assign ev_bus.ev_count = count_q;
  assign overrun         = overrun_q;

endmodule
